mem_map_router: RTL and testbench

Parametrised memory-map router between the pipelined processor's data-memory port and the instruction ROM, data RAM and a multi-channel GPIO bank. It decodes each request by address range and forwards writes to RAM. Read data comes back registered, one cycle later, with a valid flag. It also owns the synchronised GPIO input channels, the GPIO output registers and the per-channel output-write flags used by the testbench logger.

---
 rtl/mem_map_router.sv | 151 +++++++++++++++
 tb/tb_mem_map_router.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_map_router.sv
// Data-port address decoder: ROM/RAM forwarding, GPIO in/out channels.
// Optional rising-edge latches on inputs with GPIO_EDGE_CAPTURE_EN.
module mem_map_router #(
   parameter int unsigned      ROM_END = 735,
   parameter int unsigned      RAM_END = 33135,
   parameter int unsigned      IO_BASE = 33135,
   parameter int unsigned      N_IN    = 1,
   parameter int unsigned      N_OUT   = 1,
   parameter logic [N_OUT-1:0] OUT_RST = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             we,
   input  logic [31:0]      address,
   input  logic [31:0]      wd,
   output logic [31:0]      rd,
   output logic             rvalid,
   output logic             err,
   output logic [31:0]      mem_addr,
   output logic             ram_we,
   input  logic [31:0]      rom_rdata,
   input  logic [31:0]      ram_rdata,
   input  logic [N_IN-1:0]  gpio_in,
   output logic [N_OUT-1:0] gpio_out,
   output logic [N_OUT-1:0] gpio_flag
);

   localparam logic [31:0] ROM_E = 32'(ROM_END);
   localparam logic [31:0] RAM_E = 32'(RAM_END);
   localparam logic [31:0] IN_B  = 32'(IO_BASE);
   localparam logic [31:0] OUT_B = 32'(IO_BASE + N_IN);

   logic              hit_rom, hit_ram, hit_in, hit_out, hit_edge;
   logic              mapped, rd_req, wr_req, bad_acc;
   logic              in_bit, out_bit, edge_bit;
   logic [N_IN-1:0]   in_sel, edge_sel, sync1, in_sync;
   logic [N_OUT-1:0]  out_sel;
   logic [31:0]       rdata;
   logic              unused_wd;

   assign unused_wd = ^wd[31:1];

   // One-hot channel selects for the input and output GPIO windows
   always_comb begin
      in_sel  = '0;
      out_sel = '0;
      for (int k = 0; k < int'(N_IN); k++)
         in_sel[k] = (address == IN_B + 32'(k));
      for (int k = 0; k < int'(N_OUT); k++)
         out_sel[k] = (address == OUT_B + 32'(k));
   end

`ifdef GPIO_EDGE_CAPTURE_EN
   localparam logic [31:0] EDG_B = 32'(IO_BASE + N_IN + N_OUT);

   logic [N_IN-1:0] edge_q;

   // Edge-latch window sits directly after the output channels
   always_comb begin
      edge_sel = '0;
      for (int k = 0; k < int'(N_IN); k++)
         edge_sel[k] = (address == EDG_B + 32'(k));
   end

   assign edge_bit = |(edge_sel & edge_q);

   // Sticky rising-edge latches; a new edge beats a clearing read
   always_ff @(posedge clk) begin
      if (rst)
         edge_q <= '0;
      else
         edge_q <= (edge_q & ~(rd_req ? edge_sel : '0))
                 | (sync1 & ~in_sync);
   end
`else
   assign edge_sel = '0;
   assign edge_bit = 1'b0;
`endif

   assign hit_rom  = (address < ROM_E);
   assign hit_ram  = (address >= ROM_E) && (address < RAM_E);
   assign hit_in   = |in_sel;
   assign hit_out  = |out_sel;
   assign hit_edge = |edge_sel;
   assign mapped   = hit_rom | hit_ram | hit_in | hit_out | hit_edge;

   assign in_bit   = |(in_sel & in_sync);
   assign out_bit  = |(out_sel & gpio_out);

   assign rd_req   = req & ~we;
   assign wr_req   = req & we;
   assign bad_acc  = (rd_req & ~mapped)
                   | (wr_req & (hit_rom | hit_in | hit_edge | ~mapped));

   assign mem_addr = (hit_rom | hit_ram) ? address : '0;
   assign ram_we   = wr_req & hit_ram & ~rst;

   // Read-data source select by decoded region
   always_comb begin
      rdata = '0;
      unique case (1'b1)
         hit_rom:  rdata = rom_rdata;
         hit_ram:  rdata = ram_rdata;
         hit_in:   rdata = {31'b0, in_bit};
         hit_out:  rdata = {31'b0, out_bit};
         hit_edge: rdata = {31'b0, edge_bit};
         default:  rdata = '0;
      endcase
   end

   // Two-flop synchroniser on every GPIO input pin
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= '0;
         in_sync <= '0;
      end else begin
         sync1   <= gpio_in;
         in_sync <= sync1;
      end
   end

   // Registered read response and sticky error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         rd     <= '0;
         rvalid <= 1'b0;
         err    <= 1'b0;
      end else begin
         rvalid <= rd_req;
         if (rd_req)
            rd <= rdata;
         if (bad_acc)
            err <= 1'b1;
      end
   end

   // GPIO output registers with a one-cycle write flag per channel
   always_ff @(posedge clk) begin
      if (rst) begin
         gpio_out  <= OUT_RST;
         gpio_flag <= '0;
      end else begin
         gpio_flag <= wr_req ? out_sel : '0;
         if (wr_req)
            gpio_out <= (gpio_out & ~out_sel)
                      | (out_sel & {N_OUT{wd[0]}});
      end
   end

endmodule

// File: tb/tb_mem_map_router.sv
// Directed-vector bench for mem_map_router (N_IN=1, N_OUT=2).
// Covers edge-capture latches when GPIO_EDGE_CAPTURE_EN is defined.
module tb_mem_map_router;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        we;
   logic [31:0] address;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        rvalid;
   logic        err;
   logic [31:0] mem_addr;
   logic        ram_we;
   logic [31:0] rom_rdata;
   logic [31:0] ram_rdata;
   logic [0:0]  gpio_in;
   logic [1:0]  gpio_out;
   logic [1:0]  gpio_flag;

   int n_vec = 0;
   int n_err = 0;

   mem_map_router #(.N_IN(1), .N_OUT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .address   (address),
      .wd        (wd),
      .rd        (rd),
      .rvalid    (rvalid),
      .err       (err),
      .mem_addr  (mem_addr),
      .ram_we    (ram_we),
      .rom_rdata (rom_rdata),
      .ram_rdata (ram_rdata),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .gpio_flag (gpio_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_req(input logic [31:0] a);
      req = 1'b1; we = 1'b0; address = a;
      tick();
      req = 1'b0;
   endtask

   task automatic wr_req(input logic [31:0] a, input logic [31:0] d);
      req = 1'b1; we = 1'b1; address = a; wd = d;
      tick();
      req = 1'b0; we = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; address = '0; wd = '0;
      rom_rdata = '0; ram_rdata = '0; gpio_in = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_rd", rd, 32'h0);
      chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
      chk("rst_err", {31'b0, err}, 32'h0);
      chk("rst_gpio_out", {30'b0, gpio_out}, 32'h0);
      chk("rst_gpio_flag", {30'b0, gpio_flag}, 32'h0);

      // ROM read
      rom_rdata = 32'hDEADBEEF;
      rd_req(32'd0);
      chk("rom_rd", rd, 32'hDEADBEEF);
      chk("rom_rvalid", {31'b0, rvalid}, 32'h1);
      chk("rom_err", {31'b0, err}, 32'h0);
      chk("rom_gpio_out", {30'b0, gpio_out}, 32'h0);
      tick();
      chk("idle_rvalid", {31'b0, rvalid}, 32'h0);
      chk("idle_rd_hold", rd, 32'hDEADBEEF);

      // RAM write then read
      req = 1'b1; we = 1'b1; address = 32'd800; wd = 32'h12345678;
      #1;
      chk("ram_we", {31'b0, ram_we}, 32'h1);
      chk("ram_mem_addr", mem_addr, 32'd800);
      tick();
      req = 1'b0; we = 1'b0;
      chk("ram_wr_rvalid", {31'b0, rvalid}, 32'h0);
      ram_rdata = 32'h12345678;
      rd_req(32'd800);
      chk("ram_rd", rd, 32'h12345678);
      chk("ram_rvalid", {31'b0, rvalid}, 32'h1);

      // GPIO output channel 1
      req = 1'b1; we = 1'b1; address = 32'd33137; wd = 32'h1;
      #1;
      chk("gout_ram_we", {31'b0, ram_we}, 32'h0);
      chk("gout_mem_addr", mem_addr, 32'h0);
      tick();
      req = 1'b0; we = 1'b0;
      chk("gout_val", {30'b0, gpio_out}, 32'h2);
      chk("gout_flag", {30'b0, gpio_flag}, 32'h2);
      tick();
      chk("gout_flag_clr", {30'b0, gpio_flag}, 32'h0);
      wr_req(32'd33137, 32'h1);
      chk("gout_flag_rep", {30'b0, gpio_flag}, 32'h2);
      chk("gout_val_rep", {30'b0, gpio_out}, 32'h2);
      tick();
      rd_req(32'd33137);
      chk("gout_rd_ch1", rd, 32'h1);
      rd_req(32'd33136);
      chk("gout_rd_ch0", rd, 32'h0);

      // GPIO input through synchroniser
      gpio_in = 1'b1;
      tick();
      rd_req(32'd33135);
      chk("gin_early", rd, 32'h0);
      tick();
      rd_req(32'd33135);
      chk("gin_late", rd, 32'h1);
      chk("gin_err", {31'b0, err}, 32'h0);

`ifdef GPIO_EDGE_CAPTURE_EN
      gpio_in = 1'b0;
      repeat (3) tick();
      rd_req(32'd33138);
      chk("edge_prior", rd, 32'h1);
      gpio_in = 1'b1;
      repeat (3) tick();
      rd_req(32'd33138);
      chk("edge_set", rd, 32'h1);
      rd_req(32'd33138);
      chk("edge_clr", rd, 32'h0);
      chk("edge_err", {31'b0, err}, 32'h0);
`else
      rd_req(32'd33138);
      chk("noedge_rd", rd, 32'h0);
      chk("noedge_rvalid", {31'b0, rvalid}, 32'h1);
      chk("noedge_err", {31'b0, err}, 32'h1);
`endif

      // Request during reset is discarded
      rst = 1'b1;
      req = 1'b1; we = 1'b1; address = 32'd33136; wd = 32'h1;
      tick();
      rst = 1'b0; req = 1'b0; we = 1'b0;
      chk("rstreq_gpio_out", {30'b0, gpio_out}, 32'h0);
      chk("rstreq_flag", {30'b0, gpio_flag}, 32'h0);
      chk("rstreq_err", {31'b0, err}, 32'h0);
      chk("rstreq_rvalid", {31'b0, rvalid}, 32'h0);

      // Error paths
      rom_rdata = 32'hA5A5A5A5;
      rd_req(32'd5);
      chk("err_pre_rd", rd, 32'hA5A5A5A5);
      req = 1'b1; we = 1'b1; address = 32'd10; wd = 32'h55;
      #1;
      chk("romwr_ram_we", {31'b0, ram_we}, 32'h0);
      tick();
      req = 1'b0; we = 1'b0;
      chk("romwr_err", {31'b0, err}, 32'h1);
      chk("romwr_rvalid", {31'b0, rvalid}, 32'h0);
      rd_req(32'd40000);
      chk("unmap_rd", rd, 32'h0);
      chk("unmap_rvalid", {31'b0, rvalid}, 32'h1);
      chk("unmap_err", {31'b0, err}, 32'h1);
      repeat (3) tick();
      chk("err_sticky", {31'b0, err}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("err_cleared", {31'b0, err}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
